// File: rtl/fft_butterfly_stage_if.sv
// Butterfly stage stream bundle: operand pair in, sum/diff pair out, valid/ready on both sides.
// The master drives operands and out_ready; the slave is the butterfly stage.
interface fft_butterfly_stage_if;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_sum;
  logic [31:0] out_diff;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    output in_a, in_b, in_valid, out_ready,
    input  in_ready, out_sum, out_diff, out_valid, out_last
  );

  modport slave (
    input  in_a, in_b, in_valid, out_ready,
    output in_ready, out_sum, out_diff, out_valid, out_last
  );
endinterface

// File: rtl/fft_butterfly_stage.sv
// Radix-2 butterfly A+B / A-B, 2-cycle latency, saturating to 16 bits (halving instead with BUTTERFLY_SCALE_EN).
// Backpressure: both stages hold while the output is stalled; in_ready = !s2_vld || out_ready.
module fft_butterfly_stage #(
  parameter int N_PAIRS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_butterfly_stage_if.slave bfly,
  output logic                 sat_flag
);

  localparam int CW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [16:0] sum_re;
    logic signed [16:0] sum_im;
    logic signed [16:0] dif_re;
    logic signed [16:0] dif_im;
  } wide_t;

  cplx_t   op_a;
  cplx_t   op_b;
  wide_t   s1_nxt;
  wide_t   s1_dat;
  logic    s1_vld;
  cplx_t   s2_sum_nxt;
  cplx_t   s2_dif_nxt;
  cplx_t   s2_sum;
  cplx_t   s2_dif;
  logic    s2_vld;
  logic    s1_clip;
  logic    en;
  logic    out_xfer;
  logic    last;
  logic [CW-1:0] cnt;

`ifdef BUTTERFLY_SCALE_EN
  // Halving keeps every 17-bit result in range, so nothing can clip.
  function automatic logic [15:0] reduce(input logic signed [16:0] v);
    reduce = v[16:1];
  endfunction

  function automatic logic clips(input logic signed [16:0] v);
    clips = 1'b0 & v[0];
  endfunction
`else
  // Overflow of the 16-bit range shows as disagreement of the top two bits.
  function automatic logic [15:0] reduce(input logic signed [16:0] v);
    if (v[16] != v[15]) begin
      reduce = v[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      reduce = v[15:0];
    end
  endfunction

  function automatic logic clips(input logic signed [16:0] v);
    clips = v[16] ^ v[15];
  endfunction
`endif

  assign op_a = bfly.in_a;
  assign op_b = bfly.in_b;

  assign en            = !s2_vld || bfly.out_ready;
  assign bfly.in_ready = en;
  assign out_xfer      = s2_vld && bfly.out_ready;

  always_comb begin
    s1_nxt        = '0;
    s1_nxt.sum_re = {op_a.re[15], op_a.re} + {op_b.re[15], op_b.re};
    s1_nxt.sum_im = {op_a.im[15], op_a.im} + {op_b.im[15], op_b.im};
    s1_nxt.dif_re = {op_a.re[15], op_a.re} - {op_b.re[15], op_b.re};
    s1_nxt.dif_im = {op_a.im[15], op_a.im} - {op_b.im[15], op_b.im};
  end

  always_comb begin
    s2_sum_nxt    = '0;
    s2_dif_nxt    = '0;
    s2_sum_nxt.re = reduce(s1_dat.sum_re);
    s2_sum_nxt.im = reduce(s1_dat.sum_im);
    s2_dif_nxt.re = reduce(s1_dat.dif_re);
    s2_dif_nxt.im = reduce(s1_dat.dif_im);
    s1_clip       = clips(s1_dat.sum_re) | clips(s1_dat.sum_im) |
                    clips(s1_dat.dif_re) | clips(s1_dat.dif_im);
  end

  // Stage 1: full-precision sums; data only captured for valid pairs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else if (en) begin
      s1_vld <= bfly.in_valid;
      if (bfly.in_valid) begin
        s1_dat <= s1_nxt;
      end
    end
  end

  // Stage 2: reduced results that drive the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld <= 1'b0;
      s2_sum <= '0;
      s2_dif <= '0;
    end else if (en) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_sum <= s2_sum_nxt;
        s2_dif <= s2_dif_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (en && s1_vld && s1_clip) begin
      sat_flag <= 1'b1;
    end
  end

  assign last = s2_vld && (cnt == CW'(N_PAIRS - 1));

  // Frame position advances only on accepted outputs, so a stalled last pair keeps out_last.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (out_xfer) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

  assign bfly.out_sum   = s2_sum;
  assign bfly.out_diff  = s2_dif;
  assign bfly.out_valid = s2_vld;
  assign bfly.out_last  = last;

endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Directed bench for fft_butterfly_stage: vector table plus backpressure, framing and reset sequences.
module tb_fft_butterfly_stage;

  logic clk;
  logic rst;
  logic sat_flag;
  int   checks = 0;
  int   errors = 0;
  int   rcv;
  logic got_last [0:15];

  fft_butterfly_stage_if bif ();

  fft_butterfly_stage #(.N_PAIRS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bfly     (bif),
    .sat_flag (sat_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic [31:0] diff;
    logic        sat;
  } vec_t;

  vec_t tbl [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_red(input int v);
`ifdef BUTTERFLY_SCALE_EN
    return 16'(v >>> 1);
`else
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
`endif
  endfunction

  function automatic logic [31:0] ref_out(input logic [31:0] a, input logic [31:0] b, input bit diff);
    int ar, ai, br, bi;
    ar = int'($signed(a[31:16]));
    ai = int'($signed(a[15:0]));
    br = int'($signed(b[31:16]));
    bi = int'($signed(b[15:0]));
    if (diff) return {ref_red(ar - br), ref_red(ai - bi)};
    return {ref_red(ar + br), ref_red(ai + bi)};
  endfunction

  function automatic logic [31:0] pat_a(input int i);
    logic [15:0] re, im;
    re = 16'((i + 1) * 512);
    im = 16'(-(i + 1) * 2);
    return {re, im};
  endfunction

  function automatic logic [31:0] pat_b(input int i);
    logic [15:0] re;
    re = 16'(64 + i * 2);
    return {re, 16'h0020};
  endfunction

  // Streams n pairs; out_ready is dropped for st_len cycles starting at cycle st_start.
  task automatic stream(input int n, input int st_start, input int st_len);
    int sent;
    logic [31:0] held;
    sent = 0;
    rcv  = 0;
    held = '0;
    for (int cyc = 0; cyc < 100 && rcv < n; cyc++) begin
      bif.in_valid  = (sent < n);
      bif.in_a      = pat_a(sent);
      bif.in_b      = pat_b(sent);
      bif.out_ready = !(cyc >= st_start && cyc < st_start + st_len);
      #4;
      if (!bif.out_ready) begin
        chk("stall_in_ready", {31'd0, bif.in_ready}, 32'd0);
        chk("stall_out_valid", {31'd0, bif.out_valid}, 32'd1);
        if (cyc > st_start) chk("stall_hold", bif.out_sum, held);
        held = bif.out_sum;
      end
      if (bif.out_valid && bif.out_ready) begin
        chk("stream_sum", bif.out_sum, ref_out(pat_a(rcv), pat_b(rcv), 1'b0));
        chk("stream_diff", bif.out_diff, ref_out(pat_a(rcv), pat_b(rcv), 1'b1));
        got_last[rcv] = bif.out_last;
        rcv++;
      end
      if (bif.in_valid && bif.in_ready) sent++;
      step();
    end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    chk("stream_count", 32'(rcv), 32'(n));
  endtask

  initial begin
`ifdef BUTTERFLY_SCALE_EN
    tbl[0] = '{32'h1000_0000, 32'h0800_0400, 32'h0C00_0200, 32'h0400_FE00, 1'b0};
    tbl[1] = '{32'h0003_FFFD, 32'h0001_0005, 32'h0002_0001, 32'h0001_FFFC, 1'b0};
    tbl[2] = '{32'hFFFF_0001, 32'h0001_FFFF, 32'h0000_0000, 32'hFFFF_0001, 1'b0};
    tbl[3] = '{32'h0001_0003, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0};
    tbl[4] = '{32'h7000_0000, 32'h7000_0000, 32'h7000_0000, 32'h0000_0000, 1'b0};
    tbl[5] = '{32'h8000_8000, 32'h7FFF_8000, 32'hFFFF_8000, 32'h8000_0000, 1'b0};
`else
    tbl[0] = '{32'h1000_0000, 32'h0800_0400, 32'h1800_0400, 32'h0800_FC00, 1'b0};
    tbl[1] = '{32'h0003_FFFD, 32'h0001_0005, 32'h0004_0002, 32'h0002_FFF8, 1'b0};
    tbl[2] = '{32'hFFFF_0001, 32'h0001_FFFF, 32'h0000_0000, 32'hFFFE_0002, 1'b0};
    tbl[3] = '{32'h0001_0003, 32'h0000_0000, 32'h0001_0003, 32'h0001_0003, 1'b0};
    tbl[4] = '{32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 32'h0000_0000, 1'b1};
    tbl[5] = '{32'h8000_8000, 32'h7FFF_8000, 32'hFFFF_8000, 32'h8000_0000, 1'b1};
`endif
    for (int i = 0; i < 16; i++) got_last[i] = 1'b0;

    rst           = 1'b1;
    bif.in_valid  = 1'b0;
    bif.in_a      = '0;
    bif.in_b      = '0;
    bif.out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", {31'd0, bif.out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, bif.out_last}, 32'd0);
    chk("rst_sat_flag", {31'd0, sat_flag}, 32'd0);
    chk("rst_out_sum", bif.out_sum, 32'h0);
    chk("rst_out_diff", bif.out_diff, 32'h0);
    chk("rst_in_ready", {31'd0, bif.in_ready}, 32'd1);
    rst = 1'b0;

    // One pair at a time: not valid after one edge, valid with results after two.
    for (int i = 0; i < 6; i++) begin
      bif.in_valid = 1'b1;
      bif.in_a     = tbl[i].a;
      bif.in_b     = tbl[i].b;
      step();
      bif.in_valid = 1'b0;
      #4;
      chk("lat_early", {31'd0, bif.out_valid}, 32'd0);
      step();
      #4;
      chk("lat_valid", {31'd0, bif.out_valid}, 32'd1);
      chk("vec_sum", bif.out_sum, tbl[i].sum);
      chk("vec_diff", bif.out_diff, tbl[i].diff);
      chk("vec_sat", {31'd0, sat_flag}, {31'd0, tbl[i].sat});
      step();
    end

    rst = 1'b1;
    step();
    rst = 1'b0;
    stream(8, 5, 3);

    rst = 1'b1;
    step();
    rst = 1'b0;
    stream(9, -1, 0);
    for (int i = 0; i < 9; i++) begin
      chk("frame_last", {31'd0, got_last[i]}, {31'd0, (i == 3 || i == 7)});
    end

    // Fill both stages with a clipping pair under stall, then reset over it.
    bif.out_ready = 1'b0;
    bif.in_valid  = 1'b1;
    bif.in_a      = 32'h7000_0000;
    bif.in_b      = 32'h7000_0000;
    step();
    step();
    chk("full_out_valid", {31'd0, bif.out_valid}, 32'd1);
    chk("full_in_ready", {31'd0, bif.in_ready}, 32'd0);
`ifdef BUTTERFLY_SCALE_EN
    chk("full_sat", {31'd0, sat_flag}, 32'd0);
`else
    chk("full_sat", {31'd0, sat_flag}, 32'd1);
`endif
    rst = 1'b1;
    step();
    rst          = 1'b0;
    bif.in_valid = 1'b0;
    bif.out_ready = 1'b1;
    chk("mid_rst_out_valid", {31'd0, bif.out_valid}, 32'd0);
    chk("mid_rst_out_last", {31'd0, bif.out_last}, 32'd0);
    chk("mid_rst_sat", {31'd0, sat_flag}, 32'd0);
    chk("mid_rst_sum", bif.out_sum, 32'h0);
    for (int i = 0; i < 16; i++) got_last[i] = 1'b0;
    stream(4, -1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_last", {31'd0, got_last[i]}, {31'd0, (i == 3)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_butterfly_stage.md
FFT_BUTTERFLY_STAGE -- requirements
Module: fft_butterfly_stage

Interface
REQ-001 Parameter: N_PAIRS, default 4, number of butterfly pairs per FFT frame (power of two, 2..256).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_a  input  32  upper operand, packed {re[31:16], im[15:0]}, each signed 16-bit.
REQ-005 in_b  input  32  lower operand, already twiddle-multiplied, same packing as in_a.
REQ-006 in_valid  input  1  in_a/in_b hold a valid pair.
REQ-007 in_ready  output  1  stage accepts a pair this cycle.
REQ-008 out_sum  output  32  A+B, packed {re, im}.
REQ-009 out_diff  output  32  A-B, packed {re, im}.
REQ-010 out_valid  output  1  out_sum/out_diff are valid.
REQ-011 out_ready  input  1  downstream accepts the output this cycle.
REQ-012 out_last  output  1  qualifies the final pair of a frame; meaningful only with out_valid.
REQ-013 sat_flag  output  1  sticky: some output component was clipped since reset.

Function
REQ-014 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-015 Pipeline has two register stages: S1 holds 17-bit signed re/im sum and difference; S2 holds the 16-bit results driven on the outputs.
REQ-016 Latency from input transfer to out_valid is exactly 2 cycles when out_ready is held high.
REQ-017 Throughput is one pair per cycle while out_ready is high.
REQ-018 Advance enable is en = !S2_valid || out_ready; in_ready = en, combinationally.
REQ-019 When en=1, S2 loads from S1 (including its valid bit) and S1 loads the new input (valid = in_valid).
REQ-020 When en=0, S1 and S2 hold their contents; outputs stay stable while out_valid=1 and out_ready=0.
REQ-021 A bubble in S2 with a valid S1 is filled on the next edge regardless of out_ready.
REQ-022 S1 arithmetic: re and im of A+B and A-B are computed at 17 bits after sign-extending both operands; no truncation occurs.
REQ-023 S1->S2 reduction is set by the configuration in REQ-031/REQ-032.
REQ-024 The frame counter counts output transfers modulo N_PAIRS; out_last = out_valid && (count == N_PAIRS-1).
REQ-025 On the output transfer with out_last=1, the counter wraps to 0.
REQ-026 A stalled last pair keeps out_last asserted until it transfers.
REQ-027 sat_flag sets on the S1->S2 transfer in which any of the four components clips, and clears only on rst.

Reset
REQ-028 When rst=1 at an edge, S1_valid, S2_valid, out_valid, out_last, sat_flag and the frame counter all become 0, and out_sum and out_diff become 32'h0.
REQ-029 rst overrides any simultaneous transfer; pairs in flight are discarded.
REQ-030 in_ready is 1 in the first cycle after reset.

Configuration
REQ-031 With macro BUTTERFLY_SCALE_EN defined, each 17-bit result is arithmetically shifted right by 1 (floor) to 16 bits; no clipping is possible, so sat_flag stays 0.
REQ-032 Without BUTTERFLY_SCALE_EN, each 17-bit result is saturated to 16 bits (max 16'h7FFF, min 16'h8000); clipping sets sat_flag.

Verification
REQ-033 Basic, no macro: A={1000,0000}, B={0800,0400}, out_ready=1 -> 2 cycles later out_sum={1800,0400}, out_diff={0800,FC00}.
REQ-034 Basic, with macro: same stimulus -> out_sum={0C00,0200}, out_diff={0400,FE00}.
REQ-035 Clipping: A.re=7000, B.re=7000 -> out_sum.re=7FFF and sat_flag=1 without macro; out_sum.re=7000 and sat_flag=0 with macro. A.re=8000, B.re=7FFF -> out_diff.re=8000 in both builds.
REQ-036 Backpressure: stream 8 pairs, out_ready low for 3 cycles mid-stream -> in_ready low, outputs stable, no loss or duplication, order preserved.
REQ-037 Framing: N_PAIRS=4, 9 consecutive pairs -> out_last high on pairs 4 and 8 only.
REQ-038 Reset mid-stream: rst with both stages full -> next cycle out_valid=0, counter=0, sat_flag=0; the next frame's out_last falls on its 4th pair.
